cnt_wrap_watch: RTL and testbench
=================================

Name: cnt_wrap_watch

Overview:
- Downstream consumer of the free-running 4-bit counter.
- Tracks the counter's `cnt` bus every clock and detects wrap events (max -> 0) and sequence faults.
- Counts wraps against a programmable period and raises a level interrupt with an ack handshake.
- Provides the CPU timer-tick source.

Parameters:
- CNT_W, 4: width of the observed counter value.
- WRAP_W, 8: width of the period register and the wrap counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cnt_in  input  CNT_W  counter value from the upstream counter.
- arm  input  1  start request; sampled only in IDLE.
- period  input  WRAP_W  wraps per interrupt; latched on accepted arm.
- ack  input  1  interrupt acknowledge; sampled only in FIRED.
- irq  output  1  interrupt request; level, held until ack.
- busy  output  1  high in RUN or FIRED.
- wrap_count  output  WRAP_W  wraps counted since arm.
- overrun  output  1  sticky; a wrap occurred while irq was pending.
- seq_err  output  1  sticky; upstream count sequence broken.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. While rst=1:
  - state=IDLE.
  - irq, busy, overrun, seq_err = 0.
  - wrap_count = 0, period_q = 0, cnt_q = 0, cnt_vld = 0.
- Tracking register: cnt_q <= cnt_in every cycle. cnt_vld <= 1 on the first cycle after reset release.
- wrap (combinational): cnt_vld & (cnt_q == 2^CNT_W-1) & (cnt_in == 0).
- restart (combinational): cnt_vld & (cnt_in == 0) & (cnt_q != 0) & (cnt_q != max). This is an upstream sync reset. It is not a wrap and not an error.
- hold: cnt_in == cnt_q. This is upstream held in reset at 0; it is only legal when cnt_in == 0.
- seq_err set condition: cnt_vld & !wrap & !restart & !(cnt_in == 0 & cnt_q == 0) & (cnt_in != cnt_q + 1). All arithmetic is modulo 2^CNT_W.
  - seq_err is sticky and is cleared only by rst or by an accepted arm.
- FSM (encoding in package):
  - IDLE:
    - arm=1 and period != 0 -> RUN. Same edge: period_q <= period, wrap_count <= 0, overrun <= 0, seq_err <= 0.
    - arm=1 with period == 0 is ignored; state stays IDLE, no register changes.
  - RUN:
    - On wrap: wrap_count <= wrap_count + 1.
    - If wrap and (wrap_count + 1 == period_q) -> FIRED. irq=1 from the same edge.
    - arm is ignored. restart does not change wrap_count.
  - FIRED:
    - irq=1 and wrap_count holds at period_q.
    - wrap with ack=0 -> overrun <= 1; wrap_count does not increment.
    - ack=1 -> IDLE on the next edge; irq=0 from that edge.
    - ack and wrap in the same cycle: ack wins, overrun is not set.
- Outputs: busy = (state != IDLE), registered from state. wrap_count is registered and saturates at period_q.
- Latency: a wrap presented on cnt_in at cycle N is reflected in wrap_count and irq after edge N+1.
- Reset mid-operation: immediate return to IDLE with all outputs 0. cnt_vld is cleared, so the first sample after release never flags seq_err or wrap.
- Width rule: the wrap_count + 1 comparison is done at WRAP_W+1 bits to avoid aliasing at period = 2^WRAP_W-1.

Decomposition:
- Shared package `cnt_watch_pkg`:
  - typedef for the state enum {IDLE, RUN, FIRED}, 2-bit.
  - localparams CNT_MAX and WRAP_MAX derived from the widths.
- One sub-module, `cnt_wrap_det`:
  - Inputs: clk, rst, cnt_in.
  - Contents: the cnt_q / cnt_vld registers.
  - Outputs: the wrap, restart and seq_fault pulses.
- Top level: FSM, wrap counter, sticky flags.

Test Plan:
- Free-running counter, arm with period=3 at count 5 -> wrap_count goes 1/2/3 on the edges after the 15->0 transitions; irq rises with wrap_count=3 about 42 cycles later; busy=1 throughout.
- irq pending with no ack for one more full count cycle (16 clks) -> overrun=1 and wrap_count stays 3. Then ack=1 -> irq=0 and busy=0 next edge. A new arm clears overrun.
- ack asserted exactly in the cnt_in 15->0 cycle while FIRED -> IDLE, overrun stays 0.
- Upstream rst_n pulse forcing cnt_in 9->0, held 0 for one cycle, then counting 1,2,... -> seq_err stays 0 and wrap_count unchanged. Injected jump 4->7 -> seq_err=1 (sticky).
- arm with period=0 -> stays IDLE, busy=0. arm during RUN with period=9 -> ignored, period_q keeps 3.
- rst asserted mid-RUN at wrap_count=2, asynchronously between edges -> all outputs 0 immediately. After release, first sample produces no wrap or seq_err even if cnt_in=0 after 15.

Source files
------------

// File: rtl/cnt_watch_pkg.sv
// Shared types and constants for the counter wrap watcher.
package cnt_watch_pkg;

    localparam int CNT_W_DEF  = 4;
    localparam int WRAP_W_DEF = 8;

    // Largest values the observed counter and the wrap counter can hold.
    localparam logic [CNT_W_DEF-1:0]  CNT_MAX  = '1;
    localparam logic [WRAP_W_DEF-1:0] WRAP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIRED = 2'd2
    } watch_state_e;

endpackage : cnt_watch_pkg

// File: rtl/cnt_wrap_det.sv
// Samples the upstream counter each clock and classifies every step as a
// wrap (max -> 0), an upstream restart (mid-count -> 0), or a sequence fault.
module cnt_wrap_det
    import cnt_watch_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             wrap,
    output logic             restart,
    output logic             seq_fault
);

    localparam logic [CNT_W-1:0] MAX_VAL = '1;

    logic [CNT_W-1:0] cnt_q;
    logic             cnt_vld_q;

    // Previous counter sample; cnt_vld_q masks the first sample after reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            cnt_vld_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_in;
            cnt_vld_q <= 1'b1;
        end
    end

    // Step classification against the previous sample (modulo 2^CNT_W).
    // NOTE: every output gets a default first so no latch can be inferred.
    always_comb begin
        logic in_zero;
        logic q_zero;
        logic q_max;
        logic in_next;

        wrap      = 1'b0;
        restart   = 1'b0;
        seq_fault = 1'b0;

        in_zero = (cnt_in == '0);
        q_zero  = (cnt_q == '0);
        q_max   = (cnt_q == MAX_VAL);
        in_next = (cnt_in == cnt_q + CNT_W'(1));

        if (cnt_vld_q) begin
            wrap      = q_max && in_zero;
            restart   = in_zero && !q_zero && !q_max;
            // Holding at zero models upstream sitting in reset; legal.
            seq_fault = !wrap && !restart && !(in_zero && q_zero) && !in_next;
        end
    end

endmodule : cnt_wrap_det

// File: rtl/cnt_wrap_watch.sv
// Counts upstream counter wraps against a programmable period and raises a
// level interrupt held until acknowledged; tracks overrun and sequence faults.
module cnt_wrap_watch
    import cnt_watch_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WRAP_W = WRAP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              arm,
    input  logic [WRAP_W-1:0] period,
    input  logic              ack,
    output logic              irq,
    output logic              busy,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              overrun,
    output logic              seq_err
);

    logic wrap;
    logic restart;
    logic seq_fault;

    watch_state_e      state_q;
    logic [WRAP_W-1:0] period_q;
    logic [WRAP_W-1:0] wrap_count_q;
    logic              irq_q;
    logic              busy_q;
    logic              overrun_q;
    logic              seq_err_q;

    // One bit wider than the counter so a period of all-ones cannot alias.
    logic [WRAP_W:0]   wrap_count_d;

    cnt_wrap_det #(
        .CNT_W (CNT_W)
    ) u_det (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .wrap      (wrap),
        .restart   (restart),
        .seq_fault (seq_fault)
    );

    // Candidate wrap count if the current cycle carries a wrap.
    always_comb begin
        wrap_count_d = {1'b0, wrap_count_q} + (WRAP_W + 1)'(1);
    end

    // Control FSM with registered irq/busy, wrap counter and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            period_q     <= '0;
            wrap_count_q <= '0;
            irq_q        <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A zero period would never fire; such an arm is dropped.
                    if (arm && (period != '0)) begin
                        state_q      <= RUN;
                        busy_q       <= 1'b1;
                        period_q     <= period;
                        wrap_count_q <= '0;
                        overrun_q    <= 1'b0;
                        seq_err_q    <= 1'b0;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        wrap_count_q <= wrap_count_d[WRAP_W-1:0];
                        if (wrap_count_d == {1'b0, period_q}) begin
                            state_q <= FIRED;
                            irq_q   <= 1'b1;
                        end
                    end
                end
                FIRED: begin
                    // Acknowledge takes priority over a coincident wrap.
                    if (ack) begin
                        state_q <= IDLE;
                        irq_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (wrap) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase

            // A fault in the arm cycle itself still latches.
            if (seq_fault) begin
                seq_err_q <= 1'b1;
            end
        end
    end

    assign irq        = irq_q;
    assign busy       = busy_q;
    assign wrap_count = wrap_count_q;
    assign overrun    = overrun_q;
    assign seq_err    = seq_err_q;

endmodule : cnt_wrap_watch

// File: tb/tb_cnt_wrap_watch.sv
// Scoreboard bench for cnt_wrap_watch: a driver feeds directed and random
// upstream count sequences, a behavioural model pushes the expected outputs
// per cycle, and an independent monitor pops and compares after each edge.
module tb_cnt_wrap_watch;

    typedef struct packed {
        logic       irq;
        logic       busy;
        logic [7:0] wc;
        logic       ovr;
        logic       err;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cnt_in;
    logic       arm;
    logic [7:0] period;
    logic       ack;
    logic       irq;
    logic       busy;
    logic [7:0] wrap_count;
    logic       overrun;
    logic       seq_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cycle  = 0;
    obs_t exp_q[$];

    // Behavioural reference state.
    bit   m_have;
    int   m_prev;
    bit   m_busy, m_irq, m_ovr, m_err;
    int   m_count, m_period;
    logic [3:0] up;

    cnt_wrap_watch dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .arm        (arm),
        .period     (period),
        .ack        (ack),
        .irq        (irq),
        .busy       (busy),
        .wrap_count (wrap_count),
        .overrun    (overrun),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t dut_obs();
        return '{irq: irq, busy: busy, wc: wrap_count, ovr: overrun, err: seq_err};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got irq=%b busy=%b wc=%0d ovr=%b err=%b, want irq=%b busy=%b wc=%0d ovr=%b err=%b",
                     name, got.irq, got.busy, got.wc, got.ovr, got.err,
                     want.irq, want.busy, want.wc, want.ovr, want.err);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_prev = 0;
        m_busy = 0; m_irq = 0; m_ovr = 0; m_err = 0;
        m_count = 0; m_period = 0;
    endtask

    // Applies one clock of the watcher's rules to the model, in plain terms.
    task automatic model_step(input int c, input bit a, input int p, input bit k);
        bit wrapped = 0;
        bit fault   = 0;
        if (m_have) begin
            bit restarted;
            bit zero_hold;
            wrapped   = (m_prev == 15) && (c == 0);
            restarted = (c == 0) && (m_prev != 0) && (m_prev != 15);
            zero_hold = (c == 0) && (m_prev == 0);
            fault     = !(c == (m_prev + 1) % 16) && !restarted && !zero_hold;
        end
        if (!m_busy) begin
            if (a && p != 0) begin
                m_busy = 1; m_period = p; m_count = 0; m_ovr = 0; m_err = 0;
            end
        end else if (!m_irq) begin
            if (wrapped) begin
                m_count++;
                if (m_count == m_period) m_irq = 1;
            end
        end else begin
            if (k) begin
                m_irq = 0; m_busy = 0;
            end else if (wrapped) begin
                m_ovr = 1;
            end
        end
        if (fault) m_err = 1;
        m_prev = c;
        m_have = 1;
        exp_q.push_back('{irq: m_irq, busy: m_busy, wc: 8'(m_count), ovr: m_ovr, err: m_err});
    endtask

    // Drives one cycle of inputs on the falling edge and records the expectation.
    task automatic cycle(input logic [3:0] c, input logic a, input logic [7:0] p, input logic k);
        @(negedge clk);
        cnt_in = c; arm = a; period = p; ack = k;
        model_step(int'(c), a, int'(p), k);
    endtask

    task automatic step(input logic a, input logic [7:0] p, input logic k);
        cycle(up, a, p, k);
        up = up + 4'd1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0);
    endtask

    // Free-runs until the next value to be driven equals target.
    task automatic run_to(input logic [3:0] target);
        while (up != target) step(1'b0, 8'd0, 1'b0);
    endtask

    task automatic run_until_irq(input string name, input int budget);
        int n = 0;
        while (!m_irq && n < budget) begin
            step(1'b0, 8'd0, 1'b0);
            n++;
        end
        n_checks++;
        if (!m_irq) begin
            n_fail++;
            $display("FAIL %s: interrupt not reached within %0d cycles, want irq=1", name, budget);
        end
    endtask

    task automatic run_until_count(input int target, input int budget);
        int n = 0;
        while (m_count < target && n < budget) begin
            step(1'b0, 8'd0, 1'b0);
            n++;
        end
        n_checks++;
        if (m_count < target) begin
            n_fail++;
            $display("FAIL count_wait: wrap count %0d after %0d cycles, want %0d", m_count, budget, target);
        end
    endtask

    // Monitor: compares the DUT against each queued expectation after the edge.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cycle++;
                check($sformatf("cycle_%0d", n_cycle), dut_obs(), e);
            end
        end
    end

    initial begin
        cnt_in = '0; arm = 0; period = '0; ack = 0; up = '0;
        model_reset();
        rst = 0;
        #1 rst = 1;
        #1 check("reset_state", dut_obs(), '0);
        repeat (2) @(posedge clk);
        #2 rst = 0;

        // Arm period 3 at count 5, fire after three wraps.
        run_to(4'd5);
        step(1'b1, 8'd3, 1'b0);
        run_until_irq("fire_p3", 60);
        // Unacknowledged for a full count cycle -> overrun, count holds.
        run(17);
        step(1'b0, 8'd0, 1'b1);
        run(2);
        step(1'b1, 8'd3, 1'b0);
        run_until_irq("fire_p3_b", 60);

        // Ack exactly in the wrap cycle: ack wins, no overrun.
        run_to(4'd0);
        step(1'b0, 8'd0, 1'b1);
        run(3);

        // Upstream restart 9->0, hold 0, then 1,2,... is legal.
        step(1'b1, 8'd3, 1'b0);
        run_to(4'd9);
        step(1'b0, 8'd0, 1'b0);
        cycle(4'd0, 1'b0, 8'd0, 1'b0);
        cycle(4'd0, 1'b0, 8'd0, 1'b0);
        up = 4'd1;
        run(20);
        // Injected jump 4 -> 7 latches seq_err.
        run_to(4'd4);
        step(1'b0, 8'd0, 1'b0);
        up = 4'd7;
        run(5);
        run_until_irq("fire_after_restart", 60);
        step(1'b0, 8'd0, 1'b1);

        // Zero period ignored; arm during RUN ignored.
        step(1'b1, 8'd0, 1'b0);
        run(3);
        step(1'b1, 8'd3, 1'b0);
        run(2);
        step(1'b1, 8'd9, 1'b0);
        run_until_irq("fire_keep_p3", 60);
        step(1'b0, 8'd0, 1'b1);

        // Asynchronous reset mid-RUN at wrap count 2, last sample 15.
        step(1'b1, 8'd3, 1'b0);
        run_until_count(2, 60);
        run_to(4'd0);
        @(posedge clk);
        #3 rst = 1;
        #1 check("async_reset", dut_obs(), '0);
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #2 rst = 0;
        run(20);

        // Boundary periods: 1 and all-ones.
        step(1'b1, 8'd1, 1'b0);
        run_until_irq("fire_p1", 20);
        step(1'b0, 8'd0, 1'b1);
        step(1'b1, 8'd255, 1'b0);
        run_until_irq("fire_p255", 255 * 16 + 20);
        run(3);
        step(1'b0, 8'd0, 1'b1);

        // Randomized traffic with occasional upstream disturbances.
        for (int i = 0; i < 3000; i++) begin
            int r = int'($urandom_range(0, 99));
            logic a = ($urandom_range(0, 7) == 0);
            logic k = ($urandom_range(0, 5) == 0);
            logic [7:0] p = 8'($urandom_range(0, 3));
            if (r < 2) begin
                up = 4'($urandom_range(0, 15));
            end else if (r < 4) begin
                cycle(4'd0, a, p, k);
                up = 4'd1;
                continue;
            end
            step(a, p, k);
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cnt_wrap_watch
